// File: rtl/sys_bridge_mc.sv
// Registered CPU-to-slave bridge with req/ack handshake, wait-state timeout,
// word-only write enforcement and a one-cycle interrupt-acknowledge strobe.
module sys_bridge_mc #(
    parameter int                 NSLV         = 3,
    parameter logic [NSLV*32-1:0] SLV_BASE     = {32'h7F10, 32'h7F00, 32'h0000},
    parameter logic [NSLV*32-1:0] SLV_LIMIT    = {32'h7F1B, 32'h7F0B, 32'h2FFF},
    parameter logic [NSLV-1:0]    SLV_WORDONLY = 3'b110,
    parameter logic [31:0]        INT_BASE     = 32'h7F20,
    parameter int                 TIMEOUT      = 16,
    parameter logic [31:0]        ERR_CODE     = 32'h7FFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    input  logic [3:0]           cpu_byteen,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ready,
    output logic                 cpu_err,
    output logic [NSLV-1:0]      s_sel,
    output logic [31:0]          s_addr,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_byteen,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV*32-1:0]   s_rdata,
    output logic [31:0]          m_int_addr,
    output logic [3:0]           m_int_byteen
);

    // state  | meaning
    // IDLE   | waiting for cpu_req, decode happens here
    // ACCESS | slave selected, waiting for ack or timeout
    // RESP   | cpu_ready pulse, response data valid
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} bridgeState;

    bridgeState      state;
    logic [15:0]     waitCnt;
    logic [NSLV-1:0] hitVec;
    logic            hitWordOnly;
    logic            hitInt;
    logic            wordViolation;
    logic            ackSel;
    logic [31:0]     rdataSel;

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        hitVec      = '0;
        hitWordOnly = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (cpu_addr >= SLV_BASE[32*i +: 32] && cpu_addr <= SLV_LIMIT[32*i +: 32]) begin
                hitVec      = '0;
                hitVec[i]   = 1'b1;
                hitWordOnly = SLV_WORDONLY[i];
            end
        end
    end

    assign hitInt        = (cpu_addr >= INT_BASE) && (cpu_addr <= INT_BASE + 32'd3);
    assign wordViolation = hitWordOnly && (cpu_byteen != 4'b0000) && (cpu_byteen != 4'b1111);
    assign ackSel        = |(s_ack & s_sel);

    always_comb begin
        rdataSel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (s_sel[i]) rdataSel = s_rdata[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            waitCnt      <= '0;
            s_sel        <= '0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_byteen     <= '0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
            cpu_err      <= 1'b0;
            m_int_addr   <= '0;
            m_int_byteen <= '0;
        end else begin
            cpu_ready    <= 1'b0;
            m_int_addr   <= '0;
            m_int_byteen <= '0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (|hitVec && !wordViolation) begin
                            s_sel    <= hitVec;
                            s_addr   <= hitWordOnly ? {cpu_addr[31:2], 2'b00} : cpu_addr;
                            s_wdata  <= cpu_wdata;
                            s_byteen <= cpu_byteen;
                            waitCnt  <= '0;
                            state    <= ACCESS;
                        end else if (!(|hitVec) && hitInt) begin
                            m_int_addr   <= cpu_addr;
                            m_int_byteen <= cpu_byteen;
                            cpu_rdata    <= '0;
                            cpu_err      <= 1'b0;
                            cpu_ready    <= 1'b1;
                            state        <= RESP;
                        end else begin
                            cpu_rdata <= ERR_CODE;
                            cpu_err   <= 1'b1;
                            cpu_ready <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    if (ackSel) begin
                        s_sel     <= '0;
                        cpu_rdata <= (s_byteen == 4'b0000) ? rdataSel : 32'h0;
                        cpu_err   <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else if (waitCnt == 16'(TIMEOUT - 1)) begin
                        s_sel     <= '0;
                        cpu_rdata <= ERR_CODE;
                        cpu_err   <= 1'b1;
                        cpu_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        waitCnt <= waitCnt + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bridge_mc.sv
// Directed bench for sys_bridge_mc: slave model with programmable wait states,
// decode/word-only/INT/timeout cases and an asynchronous reset mid-access.
module tb_sys_bridge_mc;
    localparam int NSLV = 3;
    localparam logic [31:0] ERR = 32'h7FFF_FFFF;

    logic                clk = 1'b0;
    logic                reset;
    logic                cpu_req;
    logic [31:0]         cpu_addr, cpu_wdata;
    logic [3:0]          cpu_byteen;
    logic [31:0]         cpu_rdata;
    logic                cpu_ready, cpu_err;
    logic [NSLV-1:0]     s_sel, s_ack;
    logic [31:0]         s_addr, s_wdata;
    logic [3:0]          s_byteen;
    logic [NSLV*32-1:0]  s_rdata;
    logic [31:0]         m_int_addr;
    logic [3:0]          m_int_byteen;

    logic                ackEnable;
    logic [NSLV-1:0]     ackStray;
    int                  ackWait;
    int                  selAge = 0;
    logic [31:0]         rd0, rd1, rd2;

    int                  nAssert = 0;
    int                  nFail = 0;
    int                  lat, selCycles, intCycles;
    logic [NSLV-1:0]     selVal;
    logic [31:0]         intAddr;
    logic [3:0]          intByteen;

    sys_bridge_mc dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .s_sel(s_sel), .s_addr(s_addr), .s_wdata(s_wdata), .s_byteen(s_byteen),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen)
    );

    always #5 clk = ~clk;

    // Slave model: ack rises once s_sel has been seen for ackWait+1 negedges.
    always @(negedge clk) selAge <= (s_sel != '0) ? selAge + 1 : 0;
    assign s_ack   = ((ackEnable && selAge >= ackWait + 1) ? s_sel : '0) | ackStray;
    assign s_rdata = {rd2, rd1, rd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic doAccess(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_byteen = be;
        lat = 0; selCycles = 0; intCycles = 0; selVal = '0; intAddr = '0; intByteen = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (s_sel != '0) begin selCycles++; selVal = s_sel; end
            if (m_int_addr != '0 || m_int_byteen != '0) begin
                intCycles++; intAddr = m_int_addr; intByteen = m_int_byteen;
            end
            if (cpu_ready) break;
        end
        cpu_req = 1'b0;
        check("ready_seen", {31'b0, cpu_ready}, 32'd1);
        @(negedge clk);
        check("ready_pulse", {31'b0, cpu_ready}, 32'd0);
        check("int_clear", m_int_addr, 32'h0);
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
        ackEnable = 1'b0; ackStray = '0; ackWait = 0;
        rd0 = 32'hDEAD_BEEF; rd1 = 32'h5555_AAAA; rd2 = 32'hCAFE_0002;
        repeat (3) @(negedge clk);
        check("rst_sel", {29'b0, s_sel}, 32'h0);
        check("rst_addr", s_addr, 32'h0);
        check("rst_wdata", s_wdata, 32'h0);
        check("rst_byteen", {28'b0, s_byteen}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ready", {31'b0, cpu_ready}, 32'h0);
        check("rst_err", {31'b0, cpu_err}, 32'h0);
        check("rst_int_addr", m_int_addr, 32'h0);
        check("rst_int_be", {28'b0, m_int_byteen}, 32'h0);
        reset = 1'b1;

        // Zero-wait read of slot 0
        ackEnable = 1'b1; ackWait = 0;
        doAccess(32'h0000_1004, 32'h0, 4'b0000);
        check("rd0_lat", lat, 2);
        check("rd0_selcyc", selCycles, 1);
        check("rd0_sel", {29'b0, selVal}, 32'h1);
        check("rd0_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("rd0_err", {31'b0, cpu_err}, 32'h0);
        check("rd0_saddr", s_addr, 32'h0000_1004);

        // Write to slot 1 with 3 wait states
        ackWait = 3;
        doAccess(32'h0000_7F04, 32'h1234_5678, 4'b1111);
        check("wr1_lat", lat, 5);
        check("wr1_selcyc", selCycles, 4);
        check("wr1_sel", {29'b0, selVal}, 32'h2);
        check("wr1_saddr", s_addr, 32'h0000_7F04);
        check("wr1_swdata", s_wdata, 32'h1234_5678);
        check("wr1_sbyteen", {28'b0, s_byteen}, 32'hF);
        check("wr1_rdata", cpu_rdata, 32'h0);
        check("wr1_err", {31'b0, cpu_err}, 32'h0);

        // Byte write to a word-only slot is rejected without a slave access
        ackWait = 0;
        doAccess(32'h0000_7F14, 32'hAAAA_BBBB, 4'b0010);
        check("wo_lat", lat, 1);
        check("wo_selcyc", selCycles, 0);
        check("wo_err", {31'b0, cpu_err}, 32'h1);
        check("wo_rdata", cpu_rdata, ERR);
        check("wo_saddr_kept", s_addr, 32'h0000_7F04);

        // Full-word write to word-only slot: address low bits forced to 0
        ackWait = 1;
        doAccess(32'h0000_7F16, 32'h0F0F_0F0F, 4'b1111);
        check("wo_ok_lat", lat, 3);
        check("wo_ok_sel", {29'b0, selVal}, 32'h4);
        check("wo_ok_saddr", s_addr, 32'h0000_7F14);
        check("wo_ok_err", {31'b0, cpu_err}, 32'h0);

        // Limit boundaries
        ackWait = 0;
        doAccess(32'h0000_7F1B, 32'h0, 4'b0000);
        check("lim2_lat", lat, 2);
        check("lim2_rdata", cpu_rdata, 32'hCAFE_0002);
        check("lim2_saddr", s_addr, 32'h0000_7F18);
        doAccess(32'h0000_2FFF, 32'h0, 4'b0000);
        check("lim0_sel", {29'b0, selVal}, 32'h1);
        check("lim0_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("lim0_saddr", s_addr, 32'h0000_2FFF);
        doAccess(32'h0000_3000, 32'h0, 4'b0000);
        check("unm3000_lat", lat, 1);
        check("unm3000_err", {31'b0, cpu_err}, 32'h1);
        doAccess(32'h0000_5000, 32'h0, 4'b0000);
        check("unm5000_selcyc", selCycles, 0);
        check("unm5000_rdata", cpu_rdata, ERR);
        doAccess(32'h0000_7F1C, 32'h0, 4'b0000);
        check("unm7f1c_err", {31'b0, cpu_err}, 32'h1);

        // Timeout on a silent slave
        ackEnable = 1'b0;
        doAccess(32'h0000_0000, 32'h0, 4'b0000);
        check("to_selcyc", selCycles, 16);
        check("to_lat", lat, 17);
        check("to_err", {31'b0, cpu_err}, 32'h1);
        check("to_rdata", cpu_rdata, ERR);

        // Ack arriving on the timeout edge wins
        ackEnable = 1'b1; ackWait = 15;
        doAccess(32'h0000_7F08, 32'h0, 4'b0000);
        check("toack_lat", lat, 17);
        check("toack_err", {31'b0, cpu_err}, 32'h0);
        check("toack_rdata", cpu_rdata, 32'h5555_AAAA);

        // Acks on non-selected slots are ignored
        ackEnable = 1'b0; ackStray = 3'b101;
        doAccess(32'h0000_7F00, 32'h0, 4'b0000);
        check("stray_lat", lat, 17);
        check("stray_err", {31'b0, cpu_err}, 32'h1);
        ackStray = '0;

        // Interrupt-acknowledge window
        doAccess(32'h0000_7F20, 32'h0000_0001, 4'b1111);
        check("int_lat", lat, 1);
        check("int_cycles", intCycles, 1);
        check("int_addr", intAddr, 32'h0000_7F20);
        check("int_be", {28'b0, intByteen}, 32'hF);
        check("int_err", {31'b0, cpu_err}, 32'h0);
        check("int_rdata", cpu_rdata, 32'h0);
        check("int_selcyc", selCycles, 0);
        doAccess(32'h0000_7F23, 32'h0, 4'b0000);
        check("int_top_addr", intAddr, 32'h0000_7F23);
        check("int_top_err", {31'b0, cpu_err}, 32'h0);
        doAccess(32'h0000_7F24, 32'h0, 4'b0000);
        check("int_past_cycles", intCycles, 0);
        check("int_past_err", {31'b0, cpu_err}, 32'h1);

        // Asynchronous reset in the middle of an access
        ackEnable = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h0000_1000; cpu_byteen = 4'b0000;
        repeat (4) @(negedge clk);
        check("arst_pre_sel", {29'b0, s_sel}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_sel", {29'b0, s_sel}, 32'h0);
        check("arst_ready", {31'b0, cpu_ready}, 32'h0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_ready_hold", {31'b0, cpu_ready}, 32'h0);
        reset = 1'b1;
        ackEnable = 1'b1; ackWait = 0; rd0 = 32'h0BAD_F00D;
        doAccess(32'h0000_1008, 32'h0, 4'b0000);
        check("post_rst_lat", lat, 2);
        check("post_rst_rdata", cpu_rdata, 32'h0BAD_F00D);
        check("post_rst_err", {31'b0, cpu_err}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
